// File: rtl/cv32e40x_pkg.sv
// Shared types for the iterative carry-less multiplier.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        CLMUL  = 2'd0,
        CLMULH = 2'd1,
        CLMULR = 2'd2
    } clmul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } clmul_state_e;

endpackage

// File: rtl/cv32e40x_clmul_step.sv
// One carry-less multiply step: folds BITS_PER_CYCLE multiplier bits into the accumulator.
module cv32e40x_clmul_step #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic [2*XLEN-1:0]         acc_i,
    input  logic [2*XLEN-1:0]         a_i,
    input  logic [BITS_PER_CYCLE-1:0] b_i,
    output logic [2*XLEN-1:0]         acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_i[j]) acc_o = acc_o ^ (a_i << j);
        end
    end

endmodule

// File: rtl/cv32e40x_alu_clmul_iter.sv
// Iterative CLMUL/CLMULH/CLMULR unit with valid/ready on both sides and early termination
// once the remaining multiplier bits are all zero.
module cv32e40x_alu_clmul_iter
    import cv32e40x_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  clmul_op_e       op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned STEPS = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    clmul_state_e      state_q, state_d;
    clmul_op_e         op_q;
    logic [2*XLEN-1:0] a_q, acc_q, acc_step;
    logic [XLEN-1:0]   b_q, b_shift, result_q, result_sel;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              accept, last_step;

    assign accept    = valid_i && (state_q == IDLE) && !kill_i;
    assign b_shift   = b_q >> BITS_PER_CYCLE;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_step = (b_shift == '0) || (cnt_inc == CNT_W'(STEPS));

    cv32e40x_clmul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i (acc_q),
        .a_i   (a_q),
        .b_i   (b_q[BITS_PER_CYCLE-1:0]),
        .acc_o (acc_step)
    );

    // Select from the step output so the final step's contribution lands in the result.
    always_comb begin
        result_sel = acc_step[XLEN-1:0];
        case (op_q)
            CLMULH:  result_sel = acc_step[2*XLEN-1:XLEN];
            CLMULR:  result_sel = acc_step[2*XLEN-2:XLEN-1];
            default: result_sel = acc_step[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (ready_i)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= CLMUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_i;
                a_q   <= {{XLEN{1'b0}}, op_a_i};
                b_q   <= op_b_i;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == BUSY && !kill_i) begin
                acc_q <= acc_step;
                a_q   <= a_q << BITS_PER_CYCLE;
                b_q   <= b_shift;
                cnt_q <= cnt_inc;
            end
            if (kill_i)                             result_q <= '0;
            else if (state_q == BUSY && last_step)  result_q <= result_sel;
        end
    end

    assign result_o = result_q;

endmodule
